ahb_sram_ctrl: RTL and testbench
================================

# ahb_sram_ctrl

Parametrised AHB-Lite SRAM slave and successor to the fixed 32-bit SRAM slave. It supports any power-of-two data width and byte-lane writes across the full bus width. It inserts a configurable number of wait states per transfer and can return ERROR responses. It sits behind the AHB interconnect decoder as a memory slave and holds its own word array, with no external memory port.

## Interface
Parameters:
- HADDR_WIDTH, 32, address bus width (10..64).
- DATA_WIDTH, 32, data bus width (32, 64, 128). Lane count NL = DATA_WIDTH/8; LB = log2(NL).
- MEM_DEPTH, 256, number of DATA_WIDTH-bit words (power of two). AW = log2(MEM_DEPTH).
- WAIT_STATES, 0, wait cycles per data phase (0..3).

Ports (name, direction, width, meaning):
- hclk, in, 1, clock.
- hresetn, in, 1, reset. Asynchronous, active-low; clock is hclk.
- hsel, in, 1, slave select.
- haddr, in, HADDR_WIDTH, byte address.
- htrans, in, 2, IDLE/BUSY/NONSEQ/SEQ.
- hwrite, in, 1, 1 = write.
- hsize, in, 3, transfer size (bytes = 2^hsize).
- hwdata, in, DATA_WIDTH, write data (data phase).
- hready, in, 1, bus-level ready.
- hrdata, out, DATA_WIDTH, read data.
- hreadyout, out, 1, slave ready.
- hresp, out, 1, 0 = OKAY, 1 = ERROR.

## Operation
- Accept condition: hsel & hready & htrans[1]. On accept, register:
  - word index haddr[AW+LB-1:LB];
  - hwrite;
  - lane mask: lanes [a, a+2^hsize), where a = haddr[LB-1:0] & ~(2^hsize-1).
- No accept: next cycle is IDLE, with hreadyout=1 and hresp=0. BUSY is treated as IDLE.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE:
  - Valid accept with WAIT_STATES>0 → WAIT; with WAIT_STATES=0 → DATA.
  - Invalid accept → ERR1 (see Configuration).
- WAIT:
  - A down-counter is loaded with WAIT_STATES on accept. hreadyout=0.
  - Counter 1 → DATA.
- DATA:
  - hreadyout=1, hresp=0.
  - Write: enabled lanes of the word take hwdata at the rising edge ending DATA. Disabled lanes are unchanged.
  - Read: hrdata = the full stored word (all lanes), read combinationally from the registered index.
  - A same-cycle new accept goes to WAIT, DATA or ERR1 as from IDLE; otherwise → IDLE.
- ERR1: hreadyout=0, hresp=1 → ERR2.
- ERR2:
  - hreadyout=1, hresp=1, no memory access.
  - A same-cycle accept is honoured; otherwise → IDLE.
- hrdata is 0 except in a read DATA cycle.
- The memory array is not reset; its contents persist across hresetn.

## Timing
- Reset values: hrdata=0, hreadyout=1, hresp=0, FSM=IDLE, wait counter=0.
- Latency: the data phase completes 1+WAIT_STATES cycles after the accepting edge. Error responses are always 2 cycles.
- Pipelining: back-to-back transfers at full rate when WAIT_STATES=0.
- Read-after-write to the same word in consecutive transfers returns the new data. The write commits at the edge that starts the read data phase, so no forwarding is needed.
- hwdata is sampled only in the final data-phase cycle (hreadyout=1).
- Address-phase signals are ignored while hreadyout=0, because hready is low bus-wide.
- Reset mid-transfer: FSM → IDLE at once and outputs return to reset values. A write whose completing edge has not occurred is dropped.

## Configuration
- Macro: AHB_SRAM_CTRL_ERR_EN.
- Defined: an accept is invalid, and enters ERR1, if any of the following holds:
  - haddr >= MEM_DEPTH*NL;
  - 2^hsize > NL;
  - haddr is not aligned to 2^hsize.
- Not defined:
  - hresp is tied to 0 and the ERR states are absent.
  - The address wraps modulo MEM_DEPTH words.
  - Misaligned addresses are aligned down.
  - An oversize hsize is treated as a full-width transfer.

## Test plan
- Defaults used unless stated: DATA_WIDTH=32, MEM_DEPTH=256, WAIT_STATES=0, macro defined.
- Word write 0xDEADBEEF to 0x10, then word read of 0x10 in the next transfer → hrdata=0xDEADBEEF, hreadyout never low.
- Byte write 0xAA to 0x11 over stored word 0x11223344 → word read of 0x10 returns 0x1122AA44. Halfword write 0x5566 to 0x12 → read returns 0x5566AA44.
- WAIT_STATES=2, read of 0x20 → hreadyout low for exactly 2 cycles, then high with data; the next NONSEQ is accepted on that cycle.
- Word read of 0x400 (out of range) → hreadyout 0/1 with hresp 1/1 over two cycles, memory unchanged. Same stimulus with the macro undefined → OKAY response with data from word 0x000.
- DATA_WIDTH=64, byte write 0x77 to 0x0F → only bits [63:56] of word 1 change. hsize=4 (128-bit) → ERROR.
- hresetn asserted during the WAIT cycle of a write → hreadyout=1, hresp=0, target word unchanged, and the next transfer proceeds normally.

Source files
------------

// File: rtl/ahb_sram_ctrl.sv
// rtl/ahb_sram_ctrl.sv - AHB-Lite SRAM slave: byte lanes, wait states, optional ERROR responses
// Define AHB_SRAM_CTRL_ERR_EN to enable range/size/alignment ERROR responses.
module ahb_sram_ctrl #(
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   hsel,
  input  logic [HADDR_WIDTH-1:0] haddr,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic [DATA_WIDTH-1:0]  hwdata,
  input  logic                   hready,
  output logic [DATA_WIDTH-1:0]  hrdata,
  output logic                   hreadyout,
  output logic                   hresp
);
  localparam int NL = DATA_WIDTH / 8;
  localparam int LB = $clog2(NL);
  localparam int AW = $clog2(MEM_DEPTH);

`ifdef AHB_SRAM_CTRL_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

  state_t                state, state_nxt;
  logic [1:0]            cnt;
  logic [AW-1:0]         idx;
  logic                  wr;
  logic [NL-1:0]         mask, mask_nxt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  take, bad;
  logic [LB-1:0]         off;
  logic [2:0]            eff_size;
  logic                  unused_in;

  assign off      = haddr[LB-1:0];
  // hreadyout gates the accept so address-phase signals are ignored while stalled
  assign take     = hsel & hready & htrans[1] & hreadyout;
  assign eff_size = (int'(hsize) > LB) ? 3'(LB) : hsize;

  // A lane is enabled when it falls in the same size-aligned block as the address
  always_comb begin
    mask_nxt = '0;
    for (int i = 0; i < NL; i++)
      mask_nxt[i] = ((LB'(i) ^ off) >> eff_size) == '0;
  end

`ifdef AHB_SRAM_CTRL_ERR_EN
  always_comb begin
    bad = (int'(hsize) > LB) || ((haddr >> (AW + LB)) != '0);
    for (int i = 0; i < LB; i++)
      if (i < int'(hsize) && off[i]) bad = 1'b1;
  end
  assign unused_in = htrans[0];
`else
  assign bad       = 1'b0;
  assign unused_in = htrans[0] ^ (^(haddr >> (AW + LB)));
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      wr    <= 1'b0;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      if (take && !bad) begin
        cnt  <= 2'(WAIT_STATES);
        idx  <= haddr[AW+LB-1:LB];
        wr   <= hwrite;
        mask <= mask_nxt;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    if (take)
      state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
    else if (state == S_WAIT)
      state_nxt = (cnt == 2'd1) ? S_DATA : S_WAIT;
    if (state == S_WAIT)
      hreadyout = 1'b0;
    if (state == S_DATA && !wr)
      hrdata = mem[idx];
`ifdef AHB_SRAM_CTRL_ERR_EN
    if (take && bad)
      state_nxt = S_ERR1;
    else if (state == S_ERR1)
      state_nxt = S_ERR2;
    if (state == S_ERR1) begin
      hreadyout = 1'b0;
      hresp     = 1'b1;
    end
    if (state == S_ERR2)
      hresp = 1'b1;
`endif
  end

  // Storage is deliberately not reset so contents survive hresetn
  always_ff @(posedge hclk) begin
    if (state == S_DATA && wr)
      for (int i = 0; i < NL; i++)
        if (mask[i]) mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb/tb_ahb_sram_ctrl.sv - directed bench for ahb_sram_ctrl (32-bit/0 WS, 32-bit/2 WS, 64-bit)
module tb_ahb_sram_ctrl;
  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  logic        sel_a, sel_w, sel_x;
  logic [31:0] rdata_a, rdata_w;
  logic [63:0] rdata_x;
  logic        rdy_a, rdy_w, rdy_x;
  logic        resp_a, resp_w, resp_x;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 hclk = ~hclk;

  ahb_sram_ctrl #(.HADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut_a (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel_a), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata[31:0]), .hready(rdy_a),
    .hrdata(rdata_a), .hreadyout(rdy_a), .hresp(resp_a));

  ahb_sram_ctrl #(.HADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut_w (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel_w), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata[31:0]), .hready(rdy_w),
    .hrdata(rdata_w), .hreadyout(rdy_w), .hresp(resp_w));

  ahb_sram_ctrl #(.HADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(256), .WAIT_STATES(0)) dut_x (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel_x), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(rdy_x),
    .hrdata(rdata_x), .hreadyout(rdy_x), .hresp(resp_x));

  function automatic logic get_rdy(int d);
    if (d == 0) return rdy_a;
    if (d == 1) return rdy_w;
    return rdy_x;
  endfunction

  function automatic logic get_resp(int d);
    if (d == 0) return resp_a;
    if (d == 1) return resp_w;
    return resp_x;
  endfunction

  function automatic logic [63:0] get_rdata(int d);
    if (d == 0) return {32'h0, rdata_a};
    if (d == 1) return {32'h0, rdata_w};
    return rdata_x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr(input int d, input logic [31:0] a, input logic w, input logic [2:0] s);
    sel_a  = (d == 0);
    sel_w  = (d == 1);
    sel_x  = (d == 2);
    haddr  = a;
    hwrite = w;
    hsize  = s;
    htrans = 2'b10;
  endtask

  task automatic idle();
    sel_a  = 1'b0;
    sel_w  = 1'b0;
    sel_x  = 1'b0;
    htrans = 2'b00;
  endtask

  // One non-pipelined transfer; reports response in first and last data-phase cycles
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] s,
                      input logic [63:0] wd, output logic [63:0] rd, output int waits,
                      output logic resp_first, output logic resp_last);
    addr(d, a, w, s);
    step();
    idle();
    hwdata     = wd;
    resp_first = get_resp(d);
    waits      = 0;
    while (!get_rdy(d) && waits < 16) begin
      step();
      waits++;
    end
    rd        = get_rdata(d);
    resp_last = get_resp(d);
    step();
  endtask

  initial begin
    logic [63:0] rd;
    int          waits;
    logic        r1, r2;

    hresetn = 1'b0;
    idle();
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hwdata = '0;
    step();
    step();
    chk("rst_ready_a", 64'(rdy_a), 64'd1);
    chk("rst_resp_a", 64'(resp_a), 64'd0);
    chk("rst_rdata_a", 64'(rdata_a), 64'd0);
    chk("rst_ready_w", 64'(rdy_w), 64'd1);
    chk("rst_rdata_x", rdata_x, 64'd0);
    hresetn = 1'b1;
    step();

    // back-to-back write then read of the same word
    addr(0, 32'h10, 1'b1, 3'd2);
    step();
    hwdata = 64'hDEADBEEF;
    addr(0, 32'h10, 1'b0, 3'd2);
    chk("b2b_wr_ready", 64'(rdy_a), 64'd1);
    step();
    idle();
    chk("b2b_rd_ready", 64'(rdy_a), 64'd1);
    chk("b2b_rd_data", 64'(rdata_a), 64'hDEADBEEF);
    step();

    // byte and halfword lane writes
    xfer(0, 32'h10, 1'b1, 3'd2, 64'h11223344, rd, waits, r1, r2);
    xfer(0, 32'h11, 1'b1, 3'd0, 64'hFFFFAAFF, rd, waits, r1, r2);
    chk("wr_phase_rdata_zero", rd, 64'd0);
    xfer(0, 32'h10, 1'b0, 3'd2, 64'h0, rd, waits, r1, r2);
    chk("byte_lane_write", rd, 64'h1122AA44);
    xfer(0, 32'h12, 1'b1, 3'd1, 64'h5566EEEE, rd, waits, r1, r2);
    xfer(0, 32'h10, 1'b0, 3'd2, 64'h0, rd, waits, r1, r2);
    chk("half_lane_write", rd, 64'h5566AA44);
    chk("half_lane_okay", 64'(r2), 64'd0);

    // misaligned word read
    xfer(0, 32'h12, 1'b0, 3'd2, 64'h0, rd, waits, r1, r2);
`ifdef AHB_SRAM_CTRL_ERR_EN
    chk("misalign_err_first", 64'(r1), 64'd1);
    chk("misalign_err_waits", 64'(waits), 64'd1);
    chk("misalign_err_last", 64'(r2), 64'd1);
`else
    chk("misalign_aligned_down", rd, 64'h5566AA44);
    chk("misalign_okay", 64'(r2), 64'd0);
`endif

    // two wait states, next NONSEQ accepted in the completing cycle
    xfer(1, 32'h20, 1'b1, 3'd2, 64'hA5A50020, rd, waits, r1, r2);
    chk("ws_write_waits", 64'(waits), 64'd2);
    xfer(1, 32'h24, 1'b1, 3'd2, 64'h5A5A0024, rd, waits, r1, r2);
    addr(1, 32'h20, 1'b0, 3'd2);
    step();
    addr(1, 32'h24, 1'b0, 3'd2);
    chk("ws_wait1", 64'(rdy_w), 64'd0);
    step();
    chk("ws_wait2", 64'(rdy_w), 64'd0);
    step();
    chk("ws_data_ready", 64'(rdy_w), 64'd1);
    chk("ws_data", 64'(rdata_w), 64'hA5A50020);
    step();
    idle();
    chk("ws_next_wait1", 64'(rdy_w), 64'd0);
    step();
    chk("ws_next_wait2", 64'(rdy_w), 64'd0);
    step();
    chk("ws_next_ready", 64'(rdy_w), 64'd1);
    chk("ws_next_data", 64'(rdata_w), 64'h5A5A0024);
    step();

    // out-of-range access
    xfer(0, 32'h0, 1'b1, 3'd2, 64'hCAFEF00D, rd, waits, r1, r2);
`ifdef AHB_SRAM_CTRL_ERR_EN
    xfer(0, 32'h400, 1'b1, 3'd2, 64'h12345678, rd, waits, r1, r2);
    chk("oor_wr_resp_first", 64'(r1), 64'd1);
    chk("oor_wr_waits", 64'(waits), 64'd1);
    chk("oor_wr_resp_last", 64'(r2), 64'd1);
    xfer(0, 32'h0, 1'b0, 3'd2, 64'h0, rd, waits, r1, r2);
    chk("oor_mem_unchanged", rd, 64'hCAFEF00D);
    xfer(0, 32'h400, 1'b0, 3'd2, 64'h0, rd, waits, r1, r2);
    chk("oor_rd_resp", 64'(r2), 64'd1);
    chk("oor_rd_data_zero", rd, 64'd0);
`else
    xfer(0, 32'h400, 1'b0, 3'd2, 64'h0, rd, waits, r1, r2);
    chk("oor_wrap_data", rd, 64'hCAFEF00D);
    chk("oor_wrap_okay", 64'(r2), 64'd0);
    chk("oor_wrap_waits", 64'(waits), 64'd0);
`endif

    // 64-bit data path
    xfer(2, 32'h08, 1'b1, 3'd3, 64'h0123456789ABCDEF, rd, waits, r1, r2);
    xfer(2, 32'h00, 1'b1, 3'd3, 64'hFEDCBA9876543210, rd, waits, r1, r2);
    xfer(2, 32'h0F, 1'b1, 3'd0, 64'h77EEEEEEEEEEEEEE, rd, waits, r1, r2);
    xfer(2, 32'h08, 1'b0, 3'd3, 64'h0, rd, waits, r1, r2);
    chk("w64_top_byte", rd, 64'h7723456789ABCDEF);
    xfer(2, 32'h00, 1'b0, 3'd3, 64'h0, rd, waits, r1, r2);
    chk("w64_word0_intact", rd, 64'hFEDCBA9876543210);
    xfer(2, 32'h00, 1'b0, 3'd4, 64'h0, rd, waits, r1, r2);
`ifdef AHB_SRAM_CTRL_ERR_EN
    chk("w64_oversize_err", 64'(r2), 64'd1);
    chk("w64_oversize_waits", 64'(waits), 64'd1);
`else
    chk("w64_oversize_full", rd, 64'hFEDCBA9876543210);
    chk("w64_oversize_okay", 64'(r2), 64'd0);
`endif

    // reset during the wait phase of a write
    xfer(1, 32'h30, 1'b1, 3'd2, 64'h0BADC0DE, rd, waits, r1, r2);
    addr(1, 32'h30, 1'b1, 3'd2);
    step();
    idle();
    hwdata = 64'hFFFFFFFF;
    chk("rst_mid_pre", 64'(rdy_w), 64'd0);
    hresetn = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(rdy_w), 64'd1);
    chk("rst_mid_resp", 64'(resp_w), 64'd0);
    step();
    hresetn = 1'b1;
    step();
    xfer(1, 32'h30, 1'b0, 3'd2, 64'h0, rd, waits, r1, r2);
    chk("rst_mid_word_kept", rd, 64'h0BADC0DE);
    chk("rst_mid_next_waits", 64'(waits), 64'd2);
    chk("rst_mid_next_okay", 64'(r2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
